// File: rtl/mempool_sub_group_tcdm_arbiter_pkg.sv
// mempool_pkg: shared TCDM payload types and sub-group sizing for the tile-to-group arbiter.
package mempool_pkg;
  localparam int unsigned NumTilesPerSubGroup = 4;
  localparam int unsigned NumSubGroupOutstanding = 8;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction
  typedef logic [idx_width(NumTilesPerSubGroup)-1:0] sub_group_tile_idx_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  be;
  } tcdm_master_req_t;
  typedef struct packed {
    logic [31:0] rdata;
  } tcdm_master_resp_t;
endpackage

// File: rtl/mempool_sub_group_tcdm_arbiter_if.sv
// mempool_sub_group_tcdm_arbiter_if: tile-side and link-side handshake bundle of the arbiter.
interface mempool_sub_group_tcdm_arbiter_if
  import mempool_pkg::*;
#(
  parameter int unsigned NumIn = NumTilesPerSubGroup,
  parameter type req_t = tcdm_master_req_t,
  parameter type resp_t = tcdm_master_resp_t
);
  req_t  [NumIn-1:0] req_i;
  logic  [NumIn-1:0] req_valid_i;
  logic  [NumIn-1:0] req_ready_o;
  resp_t [NumIn-1:0] resp_o;
  logic  [NumIn-1:0] resp_valid_o;
  logic  [NumIn-1:0] resp_ready_i;
  req_t              req_o;
  logic              req_valid_o;
  logic              req_ready_i;
  resp_t             resp_i;
  logic              resp_valid_i;
  logic              resp_ready_o;
  modport slave (
    input  req_i, req_valid_i, resp_ready_i, req_ready_i, resp_i, resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o, req_o, req_valid_o, resp_ready_o
  );
  modport master (
    output req_i, req_valid_i, resp_ready_i, req_ready_i, resp_i, resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o, req_o, req_valid_o, resp_ready_o
  );
endinterface

// File: rtl/mempool_sub_group_tcdm_arbiter_origin_fifo.sv
// mempool_tcdm_origin_fifo: counter-based FIFO recording which tile issued each outstanding request.
module mempool_tcdm_origin_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0] cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  assign full_o = cnt_q == (PtrW+1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign data_o = mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d = wr_q + PtrW'(push_i);
    rd_d = rd_q + PtrW'(pop_i);
    cnt_d = cnt_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/mempool_sub_group_tcdm_arbiter.sv
// mempool_sub_group_tcdm_arbiter: round-robin share of one TCDM link with in-order response return.
// Define MEMPOOL_TCDM_ARB_PERF_EN to build the saturating stall-cycle counter.
module mempool_sub_group_tcdm_arbiter
  import mempool_pkg::*;
#(
  parameter int unsigned NumIn = NumTilesPerSubGroup,
  parameter int unsigned MaxOutstanding = NumSubGroupOutstanding,
  parameter type req_t = tcdm_master_req_t,
  parameter type resp_t = tcdm_master_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mempool_sub_group_tcdm_arbiter_if.slave bus,
  output logic [31:0] stall_cnt_o
);
  localparam int unsigned IdxW = idx_width(NumIn);
  typedef logic [IdxW-1:0] idx_t;
  idx_t rr_q, rr_d, sel_q, sel_d, win, cand, head;
  logic lock_q, lock_d, full, empty, req_hs, resp_hs;
  // Scan downwards so the smallest offset from rr_q is the last to overwrite win.
  always_comb begin
    win = rr_q;
    cand = rr_q;
    for (int i = NumIn - 1; i >= 0; i--) begin
      cand = idx_t'((int'(rr_q) + i) % int'(NumIn));
      if (bus.req_valid_i[cand]) win = cand;
    end
    if (lock_q) win = sel_q;
  end
  assign bus.req_valid_o = bus.req_valid_i[win] && !full;
  assign bus.req_o = bus.req_i[win];
  assign req_hs = bus.req_valid_o && bus.req_ready_i;
  assign bus.resp_ready_o = bus.resp_ready_i[head] && !empty;
  assign resp_hs = bus.resp_valid_i && bus.resp_ready_o;
  always_comb begin
    bus.req_ready_o = '0;
    bus.req_ready_o[win] = req_hs;
    bus.resp_valid_o = '0;
    bus.resp_valid_o[head] = bus.resp_valid_i && !empty;
    for (int i = 0; i < NumIn; i++) bus.resp_o[i] = bus.resp_i;
    rr_d = req_hs ? idx_t'((int'(win) + 1) % int'(NumIn)) : rr_q;
    lock_d = bus.req_valid_o && !bus.req_ready_i;
    sel_d = lock_d ? win : sel_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
      sel_q <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      sel_q <= sel_d;
      lock_q <= lock_d;
    end
  end
  mempool_tcdm_origin_fifo #(.Depth(MaxOutstanding), .Width(IdxW)) i_origin_fifo (
    .clk_i,
    .rst_i,
    .push_i  (req_hs),
    .data_i  (win),
    .pop_i   (resp_hs),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
`ifdef MEMPOOL_TCDM_ARB_PERF_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (|bus.req_valid_i && !req_hs && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
`ifndef SYNTHESIS
  resp_while_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(bus.resp_valid_i && empty));
`endif
endmodule

// File: tb/tb_mempool_sub_group_tcdm_arbiter.sv
// tb_mempool_sub_group_tcdm_arbiter: directed stimulus with queue-based request/response scoreboard.
module tb_mempool_sub_group_tcdm_arbiter;
  import mempool_pkg::*;
`ifdef MEMPOOL_TCDM_ARB_PERF_EN
  localparam logic [31:0] StallExp = 32'd10;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif
  typedef struct {
    int          tile;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] stall_cnt;
  int checks = 0;
  int errors = 0;
  exp_t exp_req[$];
  exp_t exp_resp[$];
  exp_t er, es;
  logic [3:0] oh;
  mempool_sub_group_tcdm_arbiter_if bif ();
  mempool_sub_group_tcdm_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bif),
    .stall_cnt_o (stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic issue(input int t, input logic [31:0] a);
    bif.req_i[t].addr = a;
    exp_req.push_back('{t, a});
  endtask
  task automatic respond(input int t, input logic [31:0] d);
    bif.resp_i.rdata = d;
    bif.resp_valid_i = 1'b1;
    exp_resp.push_back('{t, d});
  endtask
  // Monitor: compares whatever the DUT hands over at the coming edge against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bif.req_valid_o && bif.req_ready_i) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected got addr %0h want none", bif.req_o.addr);
      end else begin
        er = exp_req.pop_front();
        oh = 4'b0001 << er.tile;
        if (bif.req_ready_o !== oh || bif.req_o.addr !== er.data) begin
          errors++;
          $display("FAIL req_grant got ready %b addr %0h want ready %b addr %0h",
                   bif.req_ready_o, bif.req_o.addr, oh, er.data);
        end
      end
    end
    if (!rst && bif.resp_valid_i && bif.resp_ready_o) begin
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got rdata %0h want none", bif.resp_i.rdata);
      end else begin
        es = exp_resp.pop_front();
        oh = 4'b0001 << es.tile;
        if (bif.resp_valid_o !== oh || bif.resp_o[es.tile].rdata !== es.data) begin
          errors++;
          $display("FAIL resp_route got valid %b rdata %0h want valid %b rdata %0h",
                   bif.resp_valid_o, bif.resp_o[es.tile].rdata, oh, es.data);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bif.req_i = '0;
    bif.req_valid_i = '0;
    bif.resp_ready_i = '0;
    bif.req_ready_i = 1'b0;
    bif.resp_i = '0;
    bif.resp_valid_i = 1'b0;
    repeat (2) tick();
    chk("rst_req_valid", 32'(bif.req_valid_o), 0);
    chk("rst_resp_valid", 32'(bif.resp_valid_o), 0);
    chk("rst_resp_ready", 32'(bif.resp_ready_o), 0);
    chk("rst_stall", stall_cnt, 0);
    bif.req_ready_i = 1'b1;
    #1 chk("rst_req_ready_idle", 32'(bif.req_ready_o), 0);
    bif.req_valid_i = 4'b0001;
    #1 chk("rst_req_ready_0", 32'(bif.req_ready_o), 32'b0001);
    bif.req_valid_i = '0;
    tick();
    rst = 1'b0;
    tick();
    // Single requester: tile 2 only.
    bif.req_valid_i = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      issue(2, 32'h2000_0000 + 32'(k));
      tick();
    end
    bif.req_valid_i = '0;
    bif.resp_ready_i = '1;
    for (int k = 0; k < 3; k++) begin
      respond(2, 32'hD200 + 32'(k));
      tick();
    end
    bif.resp_valid_i = 1'b0;
    // Fairness from a fresh pointer, running straight into the capacity gate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.req_valid_i = '1;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 4; t++) bif.req_i[t].addr = 32'hF000_0000 | (32'(t) << 8) | 32'(k);
      exp_req.push_back('{k % 4, 32'hF000_0000 | (32'(k % 4) << 8) | 32'(k)});
      tick();
    end
    chk("full_req_valid", 32'(bif.req_valid_o), 0);
    chk("full_req_ready", 32'(bif.req_ready_o), 0);
    bif.req_ready_i = 1'b0;
    respond(0, 32'hE000);
    #1 chk("full_no_bypass", 32'(bif.req_valid_o), 0);
    tick();
    bif.resp_valid_i = 1'b0;
    #1 chk("full_freed", 32'(bif.req_valid_o), 1);
    bif.req_valid_i = '0;
    for (int k = 1; k < 8; k++) begin
      respond(k % 4, 32'hE000 + 32'(k));
      tick();
    end
    bif.resp_valid_i = 1'b0;
    // Lock: tile 1 stalled while tile 0 (nearer to rr_q=0) joins.
    bif.req_i[1].addr = 32'h1111_0001;
    bif.req_i[0].addr = 32'h0000_0A0A;
    bif.req_valid_i = 4'b0010;
    #1 chk("lock_first", bif.req_o.addr, 32'h1111_0001);
    tick();
    bif.req_valid_i = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1 chk("lock_hold", bif.req_o.addr, 32'h1111_0001);
      tick();
    end
    bif.req_ready_i = 1'b1;
    exp_req.push_back('{1, 32'h1111_0001});
    tick();
    bif.req_valid_i = 4'b0001;
    exp_req.push_back('{0, 32'h0000_0A0A});
    tick();
    bif.req_valid_i = '0;
    respond(1, 32'hC001);
    tick();
    respond(0, 32'hC000);
    tick();
    bif.resp_valid_i = 1'b0;
    // Response backpressure from the head tile.
    bif.req_valid_i = 4'b1000;
    issue(3, 32'h3333_0033);
    tick();
    bif.req_valid_i = '0;
    bif.resp_i.rdata = 32'hB3;
    bif.resp_valid_i = 1'b1;
    bif.resp_ready_i = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_resp_ready", 32'(bif.resp_ready_o), 0);
      chk("bp_resp_valid", 32'(bif.resp_valid_o), 32'b1000);
      tick();
    end
    bif.resp_ready_i = '1;
    respond(3, 32'hB3);
    tick();
    bif.resp_valid_i = 1'b0;
    #1 chk("empty_resp_ready", 32'(bif.resp_ready_o), 0);
    // Stall counter, then an asynchronous reset with requests outstanding.
    bif.req_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.req_valid_i = '1;
    bif.req_i[0].addr = 32'h5000_0000;
    bif.req_i[1].addr = 32'h5000_0001;
    repeat (10) tick();
    chk("stall_10", stall_cnt, StallExp);
    bif.req_ready_i = 1'b1;
    exp_req.push_back('{0, 32'h5000_0000});
    tick();
    exp_req.push_back('{1, 32'h5000_0001});
    tick();
    bif.req_ready_i = 1'b0;
    chk("stall_hold", stall_cnt, StallExp);
    #2 rst = 1'b1;
    bif.resp_valid_i = 1'b1;
    #1 chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_resp_ready", 32'(bif.resp_ready_o), 0);
    chk("mid_rst_resp_valid", 32'(bif.resp_valid_o), 0);
    bif.resp_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    bif.req_ready_i = 1'b1;
    #1 chk("post_rst_grant", 32'(bif.req_ready_o), 32'b0001);
    bif.req_valid_i = '0;
    bif.req_ready_i = 1'b0;
    tick();
    chk("req_queue_drained", 32'(exp_req.size()), 0);
    chk("resp_queue_drained", 32'(exp_resp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mempool_sub_group_tcdm_arbiter.md
# mempool_sub_group_tcdm_arbiter

Round-robin arbiter that shares one TCDM master link of a sub-group between `NumIn` tile master ports bound for the same remote group. It sits between the tiles' per-group master ports and the sub-group boundary registers. It tracks outstanding transactions in an origin FIFO so that in-order responses are routed back to the issuing tile.

## Interface
Parameters:
- `NumIn`, 4: number of requesting tile ports; must be ≥ 2.
- `MaxOutstanding`, 8: depth of the origin FIFO; power of two, ≥ 2.
- `req_t`, `tcdm_master_req_t`: request payload type.
- `resp_t`, `tcdm_master_resp_t`: response payload type.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `req_i`  in  NumIn×req_t  per-tile request payload.
- `req_valid_i`  in  NumIn  per-tile request valid.
- `req_ready_o`  out  NumIn  per-tile request ready.
- `resp_o`  out  NumIn×resp_t  per-tile response payload; broadcast copy of `resp_i`.
- `resp_valid_o`  out  NumIn  per-tile response valid.
- `resp_ready_i`  in  NumIn  per-tile response ready.
- `req_o`  out  req_t  arbitrated request.
- `req_valid_o`  out  1  arbitrated valid.
- `req_ready_i`  in  1  downstream ready.
- `resp_i`  in  resp_t  in-order response from the link.
- `resp_valid_i`  in  1  response valid.
- `resp_ready_o`  out  1  response ready.
- `stall_cnt_o`  out  32  performance counter; see Configuration.

## Operation
- **Grant.** Round-robin over `req_valid_i`, starting at pointer `rr_q` (reset 0).
  - The winner is the first valid index ≥ `rr_q`, wrapping around.
  - On a handshake (`req_valid_o && req_ready_i`), `rr_q` ← winner+1 mod NumIn.
- **Lock.** When `req_valid_o=1 && req_ready_i=0`, the grant is held in `lock_q` and `sel_q`; it does not change until that handshake completes. This keeps `req_o` stable per valid/ready rules.
- **Capacity gate.** When the FIFO is full (`cnt_q == MaxOutstanding`), `req_valid_o=0` and all `req_ready_o=0`.
- **Request path.**
  - `req_ready_o[winner] = req_ready_i && !full`; all other bits are 0.
  - `req_o = req_i[winner]`, zero-latency combinational.
- **Push.** On a request handshake, push the winner index (`$clog2(NumIn)` bits) into the origin FIFO.
- **Response routing.**
  - Head index `h`: `resp_valid_o[h] = resp_valid_i && !empty`; all other bits are 0.
  - `resp_ready_o = resp_ready_i[h] && !empty`.
  - On a response handshake, pop the FIFO.
- **Simultaneous push and pop.** `cnt_q` is unchanged and both pointers advance. Pushing while full is impossible because of the capacity gate. Popping while full frees the slot from the next cycle on; there is no same-cycle bypass.
- **Response while empty.** `resp_ready_o=0`, so the response is never accepted. A simulation-only assertion flags it as an error.
- **Arithmetic.** FIFO pointers are `$clog2(MaxOutstanding)` bits and wrap naturally. `cnt_q` is `$clog2(MaxOutstanding)+1` bits.
- **Reset.** Reset mid-operation clears all state immediately (asynchronous). Outstanding responses are discarded; the surrounding system resets together.
- **Reset values.**
  - `rr_q=0`, `lock_q=0`, `sel_q=0`, FIFO `cnt_q=0`, `stall_cnt_o=0`.
  - `req_valid_o=0`, `resp_valid_o=0`, `resp_ready_o=0`.
  - `req_ready_o` follows `req_ready_i` for index 0 only when `req_valid_i[0]`; otherwise 0.

## Timing
- Request path: 0 cycles from input to `req_o`, combinational.
- Response path: 0 cycles, combinational through the FIFO head.
- Arbitration throughput: one grant per cycle.
- Fairness: with all inputs continuously valid, each index is granted once every NumIn handshakes.
- `rr_q`, `sel_q`, `lock_q` and the FIFO update on the rising `clk_i` edge after a handshake.
- A pop frees capacity visible in the next cycle.

## Configuration
- `MEMPOOL_TCDM_ARB_PERF_EN` defined:
  - `stall_cnt_o` counts cycles where any `req_valid_i=1` and no request handshake occurs.
  - 32-bit, saturating at 0xFFFF_FFFF; reset 0.
- Not defined: `stall_cnt_o` is tied to 0 and no counter flops are synthesized.

## Structure
- Shared package `mempool_pkg`:
  - `tcdm_master_req_t`, `tcdm_master_resp_t`, `NumTilesPerSubGroup`.
  - new constant `NumSubGroupOutstanding` = 8.
  - new typedef `sub_group_tile_idx_t = logic [idx_width(NumTilesPerSubGroup)-1:0]`.
- One sub-module: `mempool_tcdm_origin_fifo`, a plain counter-based FIFO of tile indices with full/empty/push/pop. The round-robin selection stays inline.

## Test plan
- Single requester: tile 2 issues 3 requests and `req_ready_i=1` → `req_o` equals tile 2's payloads in order. Three responses come back to `resp_valid_o[2]` only.
- Fairness: all 4 tiles valid for 8 cycles with `req_ready_i=1` → grant order 0,1,2,3,0,1,2,3.
- Lock: tile 1 granted and `req_ready_i=0` for 5 cycles while tile 0 asserts valid → `req_o` stays tile 1's payload. Tile 1 handshakes first, then tile 2, 3 or 0 follows per `rr_q`.
- Full: 8 handshakes with no responses → `req_valid_o=0` on cycle 9. One response pop → `req_valid_o=1` the following cycle.
- Backpressure and empty:
  - head tile drives `resp_ready_i=0` → `resp_ready_o=0` and the response is held.
  - `resp_valid_i` while empty → `resp_ready_o=0` and the assertion fires.
- Perf macro: all tiles valid with `req_ready_i=0` for 10 cycles → `stall_cnt_o=10` with `MEMPOOL_TCDM_ARB_PERF_EN` defined, 0 without it. Assert `rst_i` mid-run → counter and FIFO return to 0.
